// File: rtl/digit_entry_register_pkg.sv
// rtl/digit_entry_register_pkg.sv - shared types and constants for digit_entry_register (honours DIGIT_ENTRY_DEBOUNCE_EN)
package digit_entry_register_pkg;

  localparam int BCD_MAX    = 9;
  localparam int MAX_DIGITS = 4;

  typedef logic [3:0] digit_t;

  // STABLE only exists when presses are debounced.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    STABLE = 2'd1,
`endif
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/digit_entry_register_sync2.sv
// rtl/digit_entry_register_sync2.sv - two-flop synchronizer, parameterised width
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops to bring the keypad lines into the clk domain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/digit_entry_register.sv
// rtl/digit_entry_register.sv - MM:SS keypad digit entry; DIGIT_ENTRY_DEBOUNCE_EN enables debounce
module digit_entry_register
  import digit_entry_register_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       valid,
  input  logic       load_en,
  input  logic       clear,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [2:0] digit_count,
  output logic       digit_stb,
  output logic       reject
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 15) begin : g_param_check
    $error("DEBOUNCE_CYCLES must be in 2..15");
  end

  digit_t d_s;
  logic   valid_s;
  state_t state;
  state_t state_next;
  logic   eval;
  logic   code_ok;

  sync2 #(.WIDTH(5)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    ({valid, D}),
    .dout   ({valid_s, d_s})
  );

`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic [3:0] cnt;
  logic [3:0] cnt_next;
  digit_t     code_q;
  digit_t     code_next;
`endif

  // A press is only accepted if it is a decimal digit and there is room for it.
  assign code_ok = (d_s <= digit_t'(BCD_MAX)) && (digit_count < 3'(MAX_DIGITS));

  // Next-state logic: debounce press/release and decide when to evaluate a key.
  always_comb begin
    state_next = state;
    eval       = 1'b0;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
    cnt_next   = cnt;
    code_next  = code_q;
`endif
    case (state)
      IDLE: begin
        if (valid_s && load_en) begin
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
          state_next = STABLE;
          code_next  = d_s;
          cnt_next   = 4'd1;
`else
          state_next = HOLD;
          eval       = 1'b1;
`endif
        end
      end
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      STABLE: begin
        if (!valid_s || !load_en || (d_s != code_q)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = HOLD;
          eval       = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      HOLD: begin
        // cnt counts consecutive released samples; any bounce back restarts it.
        if (valid_s) begin
          cnt_next = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
`else
      HOLD: begin
        if (!valid_s) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    // clear wins over any evaluation in the same cycle.
    if (clear) begin
      state_next = IDLE;
      eval       = 1'b0;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      cnt_next   = '0;
`endif
    end
  end

  // FSM state register (plus debounce counter and latched code when present).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      cnt    <= '0;
      code_q <= '0;
`endif
    end else begin
      state  <= state_next;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
      cnt    <= cnt_next;
      code_q <= code_next;
`endif
    end
  end

  // Digit shift register, count and one-cycle result pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      min_tens    <= '0;
      min_ones    <= '0;
      sec_tens    <= '0;
      sec_ones    <= '0;
      digit_count <= '0;
      digit_stb   <= 1'b0;
      reject      <= 1'b0;
    end else begin
      digit_stb <= eval && code_ok;
      reject    <= eval && !code_ok;
      if (clear) begin
        min_tens    <= '0;
        min_ones    <= '0;
        sec_tens    <= '0;
        sec_ones    <= '0;
        digit_count <= '0;
      end else if (eval && code_ok) begin
        min_tens    <= min_ones;
        min_ones    <= sec_tens;
        sec_tens    <= sec_ones;
        sec_ones    <= d_s;
        digit_count <= digit_count + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_digit_entry_register.sv
// tb/tb_digit_entry_register.sv - self-checking bench for digit_entry_register
module tb_digit_entry_register;

  localparam int DEB = 4;
`ifdef DIGIT_ENTRY_DEBOUNCE_EN
  localparam int NEED = DEB;
  localparam int LAT  = DEB + 2;
`else
  localparam int NEED = 1;
  localparam int LAT  = 3;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] D;
  logic       valid;
  logic       load_en;
  logic       clear;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [2:0] digit_count;
  logic       digit_stb;
  logic       reject;

  digit_entry_register #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .D           (D),
    .valid       (valid),
    .load_en     (load_en),
    .clear       (clear),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .digit_stb   (digit_stb),
    .reject      (reject)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  int stb_cnt  = 0;
  int rej_cnt  = 0;
  int ev_edge  = 0;

  // Reference: accepted digits in entry order, newest last; at most 4.
  int q[$];

  always @(posedge clk) edge_n++;

  always @(negedge clk) begin
    if (digit_stb) begin
      stb_cnt++;
      ev_edge = edge_n;
    end
    if (reject) begin
      rej_cnt++;
      ev_edge = edge_n;
    end
  end

  function automatic void chk(string name, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Display position p (0 = min_tens .. 3 = sec_ones) of the right-aligned entry.
  function automatic int exp_digit(int p);
    int from_right = 3 - p;
    if (from_right < q.size()) return q[q.size() - 1 - from_right];
    return 0;
  endfunction

  task automatic check_state(string tag);
    chk({tag, "_min_tens"}, min_tens, exp_digit(0));
    chk({tag, "_min_ones"}, min_ones, exp_digit(1));
    chk({tag, "_sec_tens"}, sec_tens, exp_digit(2));
    chk({tag, "_sec_ones"}, sec_ones, exp_digit(3));
    chk({tag, "_count"}, digit_count, q.size());
  endtask

  task automatic model_eval(input int code, input bit acc, output int es, output int er);
    es = 0;
    er = 0;
    if (acc) begin
      if (code <= 9 && q.size() < 4) begin
        q.push_back(code);
        es = 1;
      end else begin
        er = 1;
      end
    end
  endtask

  task automatic drive_press(input int code, input int hold, input int gap, input bit le,
                             output int ns, output int nr, output int lat);
    int s0, r0, e0;
    @(negedge clk);
    s0 = stb_cnt;
    r0 = rej_cnt;
    e0 = edge_n;
    D = 4'(code);
    valid = 1'b1;
    load_en = le;
    repeat (hold) @(negedge clk);
    valid = 1'b0;
    D = 4'($urandom_range(0, 15));
    repeat (gap) @(negedge clk);
    load_en = 1'b1;
    ns = stb_cnt - s0;
    nr = rej_cnt - r0;
    lat = ev_edge - e0;
  endtask

  task automatic press(input int code, input int hold, input bit le);
    int ns, nr, lat, es, er;
    drive_press(code, hold, NEED + 5 + int'($urandom_range(0, 3)), le, ns, nr, lat);
    model_eval(code, le && (hold >= NEED), es, er);
    chk("press_stb", ns, es);
    chk("press_rej", nr, er);
    if (es + er > 0) chk("press_latency", lat, LAT);
    check_state("press");
  endtask

  task automatic clear_all();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    q.delete();
  endtask

  typedef struct {
    int code;
    int exp_stb;
    int exp_rej;
    int exp_count;
    int exp_sec_ones;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int ns, nr, lat, es, er, s0, r0, e0;

    tbl[0] = '{11, 0, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 1, 1};
    tbl[2] = '{2, 1, 0, 2, 2};
    tbl[3] = '{3, 1, 0, 3, 3};
    tbl[4] = '{0, 1, 0, 4, 0};
    tbl[5] = '{7, 0, 1, 4, 0};
    tbl[6] = '{9, 0, 1, 4, 0};

    resetn = 1'b0;
    D = 4'd0;
    valid = 1'b0;
    load_en = 1'b1;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_stb", digit_stb, 0);
    chk("reset_rej", reject, 0);
    resetn = 1'b1;

    // First press after reset, latency checked inside press().
    press(5, 10, 1'b1);

    // Table: fill to four digits, then saturation and invalid codes.
    clear_all();
    foreach (tbl[i]) begin
      drive_press(tbl[i].code, 10, NEED + 6, 1'b1, ns, nr, lat);
      model_eval(tbl[i].code, 1'b1, es, er);
      chk("tbl_stb", ns, tbl[i].exp_stb);
      chk("tbl_rej", nr, tbl[i].exp_rej);
      chk("tbl_count", digit_count, tbl[i].exp_count);
      chk("tbl_sec_ones", sec_ones, tbl[i].exp_sec_ones);
    end
    chk("full_min_tens", min_tens, 1);
    chk("full_min_ones", min_ones, 2);
    chk("full_sec_tens", sec_tens, 3);
    chk("full_sec_ones", sec_ones, 0);

    // clear landing on the accepting edge: everything zero, no pulses.
    clear_all();
    press(8, 10, 1'b1);
    @(negedge clk);
    s0 = stb_cnt;
    r0 = rej_cnt;
    D = 4'd4;
    valid = 1'b1;
    for (int j = 1; j <= LAT + 8; j++) begin
      @(negedge clk);
      if (j == NEED) valid = 1'b0;
      if (j == LAT - 1) clear = 1'b1;
      if (j == LAT) clear = 1'b0;
    end
    q.delete();
    chk("clr_coll_stb", stb_cnt - s0, 0);
    chk("clr_coll_rej", rej_cnt - r0, 0);
    check_state("clr_coll");

    // Short press and a key code changing mid-press.
    press(7, 3, 1'b1);
    clear_all();
    @(negedge clk);
    s0 = stb_cnt;
    r0 = rej_cnt;
    D = 4'd4;
    valid = 1'b1;
    repeat (2) @(negedge clk);
    D = 4'd6;
    repeat (2) @(negedge clk);
    valid = 1'b0;
    repeat (NEED + 8) @(negedge clk);
    model_eval(4, NEED == 1, es, er);
    chk("toggle_stb", stb_cnt - s0, es);
    chk("toggle_rej", rej_cnt - r0, er);
    check_state("toggle");

    // Long hold yields exactly one evaluation; load_en low ignores the key.
    clear_all();
    press(9, 20, 1'b1);
    press(3, 10, 1'b0);

    // Reset while a key is held, then the held key counts as a new press.
    clear_all();
    @(negedge clk);
    s0 = stb_cnt;
    D = 4'd9;
    valid = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    chk("hold_pre_rst_stb", stb_cnt - s0, 1);
    #2 resetn = 1'b0;
    #1;
    q.delete();
    check_state("async_rst");
    chk("async_rst_stb", digit_stb, 0);
    chk("async_rst_rej", reject, 0);
    @(negedge clk);
    resetn = 1'b1;
    s0 = stb_cnt;
    e0 = edge_n;
    repeat (LAT + 3) @(negedge clk);
    model_eval(9, 1'b1, es, er);
    chk("post_rst_stb", stb_cnt - s0, 1);
    chk("post_rst_latency", ev_edge - e0, LAT);
    check_state("post_rst");
    valid = 1'b0;
    repeat (NEED + 6) @(negedge clk);

    // Randomised presses against the reference.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) == 0) clear_all();
      press(int'($urandom_range(0, 15)), int'($urandom_range(1, NEED + 5)),
            $urandom_range(0, 9) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
